// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit common-anode 7-seg scanner with tear-free updates.
// Optional LZ_SUPPRESS_EN: darkens leading zero digits (digit 0 always lit).
module seven_segment (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Active-low glyph lookup, bit0=a .. bit6=g
  always_comb begin
    unique case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
    endcase
  end

endmodule

module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;

  logic [3:0]              nib;
  logic                    en_cur;
  logic                    lz_dark;
  logic                    drive;
  logic                    slot_wrap;
  logic                    frame_wrap;
  logic [6:0]              glyph_n;
  logic [NUM_DIGITS-1:0]   an_next;
`ifdef LZ_SUPPRESS_EN
  logic                    hi_nz;
`endif

  // Select the active digit's nibble/enable and decide if it is dark
  always_comb begin
    nib     = 4'h0;
    en_cur  = 1'b0;
    lz_dark = 1'b0;
`ifdef LZ_SUPPRESS_EN
    hi_nz   = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = shadow[4*i +: 4];
        en_cur = digit_en[i];
      end
`ifdef LZ_SUPPRESS_EN
      if (IW'(i) >= idx && shadow[4*i +: 4] != 4'h0)
        hi_nz = 1'b1;
`endif
    end
`ifdef LZ_SUPPRESS_EN
    lz_dark = (idx != '0) && !hi_nz;
`endif
  end

  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);
  assign drive      = (cnt >= CNT_BLANK) && en_cur && !lz_dark;

  // One-hot active-low anode pattern for the driven digit
  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      an_next[i] = !(drive && (idx == IW'(i)));
  end

  seven_segment u_dec (
    .hex   (nib),
    .seg_n (glyph_n)
  );

  // Slot timing, digit index and the staging/shadow double buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= slot_wrap ? '0 : cnt + CW'(1);
      if (slot_wrap)
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      if (frame_wrap) begin
        pending <= 1'b0;
        if (load)
          shadow <= value;
        else if (pending)
          shadow <= staging;
      end else if (load) begin
        staging <= value;
        pending <= 1'b1;
      end
    end
  end

  // Registered display outputs from the current scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n      <= 7'h7F;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= drive ? glyph_n : 7'h7F;
      an_n       <= an_next;
      frame_done <= frame_wrap;
    end
  end

endmodule
